// File: rtl/array_ops_pkg.sv
// Shared types and index helpers for streaming array assembly.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package array_ops_pkg;

  typedef enum logic {
    ORDER_ROW_FAST = 1'b0,
    ORDER_COL_FAST = 1'b1
  } order_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fill_state_e;

  function automatic int beats_per_frame(input int rows, input int cols, input int lanes);
    return (rows * cols) / lanes;
  endfunction

  // Row that element k of a frame lands in.
  function automatic int elem_row(input int k, input order_e order, input int rows, input int cols);
    return (order == ORDER_ROW_FAST) ? (k % rows) : (k / cols);
  endfunction

  // Column that element k of a frame lands in.
  function automatic int elem_col(input int k, input order_e order, input int rows, input int cols);
    return (order == ORDER_ROW_FAST) ? (k / rows) : (k % cols);
  endfunction

  // Inverse mapping: which stream element feeds out[row][col]. Elaboration-time only.
  function automatic int elem_index(input int row, input int col, input order_e order,
                                    input int rows, input int cols);
    int idx;
    idx = 0;
    for (int k = 0; k < rows * cols; k++) begin
      if (elem_row(k, order, rows, cols) == row && elem_col(k, order, rows, cols) == col) begin
        idx = k;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_array_bank.sv
// One ROWS x COLS register bank plus the fill order latched on the frame's first beat.
// Latency: an element is visible the cycle after the beat carrying it is written.
// Backpressure: none; writes whenever we is high, the caller owns flow control.
module stream_array_bank
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int LANES     = 2,
  parameter int BW        = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [BW-1:0]              beat,
  input  logic                       order,
  input  logic [LANES*BIT_WIDTH-1:0] data,
  output logic [BIT_WIDTH-1:0]       arr [ROWS][COLS]
);

  logic                 order_q;
  logic                 eff_order;
  logic                 hit [ROWS][COLS];
  logic [BIT_WIDTH-1:0] din [ROWS][COLS];

  // The first beat of a frame steers itself with the live order bit.
  assign eff_order = (beat == '0) ? order : order_q;

  // Latch the frame's fill order on its first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= ORDER_ROW_FAST;
    end else if (we && beat == '0) begin
      order_q <= order;
    end
  end

  // Each element knows, per order, which beat and lane feed it.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K0 = elem_index(r, c, ORDER_ROW_FAST, ROWS, COLS);
      localparam int K1 = elem_index(r, c, ORDER_COL_FAST, ROWS, COLS);
      localparam logic [BW-1:0] B0 = BW'(K0 / LANES);
      localparam logic [BW-1:0] B1 = BW'(K1 / LANES);
      localparam int L0 = K0 % LANES;
      localparam int L1 = K1 % LANES;

      assign hit[r][c] = we && ((eff_order == ORDER_COL_FAST) ? (beat == B1) : (beat == B0));
      assign din[r][c] = (eff_order == ORDER_COL_FAST) ? data[L1*BIT_WIDTH +: BIT_WIDTH]
                                                       : data[L0*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Element storage: cleared on reset, written when its beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          arr[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (hit[r][c]) begin
            arr[r][c] <= din[r][c];
          end
        end
      end
    end
  end

endmodule

// File: rtl/stream_to_3d_array.sv
// Assembles LANES-wide beats into a registered ROWS x COLS array; STREAM_ARRAY_DOUBLE_BUFFER_EN adds a second bank.
// Latency: out_valid rises the cycle after the final beat's handshake.
// Backpressure: in_ready drops while the array (both banks when double-buffered) waits for out_ready.
module stream_to_3d_array
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int LANES     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES*BIT_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic                       in_order,
  output logic [BIT_WIDTH-1:0]       out [ROWS][COLS],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_err
);

  localparam int BEATS = beats_per_frame(ROWS, COLS, LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((ROWS * COLS) % LANES != 0) begin : g_lane_check
    $fatal(1, "stream_to_3d_array: ROWS*COLS must be a multiple of LANES");
  end

  logic [BW-1:0] beat;
  logic          wr;
  logic          last_beat;

  assign wr        = in_valid & in_ready;
  assign last_beat = (beat == LAST_BEAT);

  // Beat position within the frame; frames always end by count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (wr) begin
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  // Flag a beat whose in_last disagrees with the count; data is kept regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= wr & (in_last ^ last_beat);
    end
  end

`ifdef STREAM_ARRAY_DOUBLE_BUFFER_EN

  logic [1:0]           full, full_nxt;
  logic                 fill_sel, fill_sel_nxt;
  logic                 front_sel, front_sel_nxt;
  logic [BIT_WIDTH-1:0] arr0 [ROWS][COLS];
  logic [BIT_WIDTH-1:0] arr1 [ROWS][COLS];

  assign in_ready  = ~(full[0] & full[1]);
  assign out_valid = full[front_sel];

  // Bank bookkeeping: the front only moves to a full back bank, so out holds
  // the last frame while the next one is still filling.
  always_comb begin
    full_nxt      = full;
    fill_sel_nxt  = fill_sel;
    front_sel_nxt = front_sel;
    if (out_valid && out_ready) begin
      full_nxt[front_sel] = 1'b0;
    end
    if (wr && last_beat) begin
      full_nxt[fill_sel] = 1'b1;
      fill_sel_nxt       = ~fill_sel;
    end
    if (!full_nxt[front_sel] && full_nxt[~front_sel]) begin
      front_sel_nxt = ~front_sel;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 2'b00;
      fill_sel  <= 1'b0;
      front_sel <= 1'b0;
    end else begin
      full      <= full_nxt;
      fill_sel  <= fill_sel_nxt;
      front_sel <= front_sel_nxt;
    end
  end

  stream_array_bank #(
    .BIT_WIDTH(BIT_WIDTH), .ROWS(ROWS), .COLS(COLS), .LANES(LANES), .BW(BW)
  ) u_bank0 (
    .clk(clk), .rst_n(rst_n), .we(wr & ~fill_sel), .beat(beat),
    .order(in_order), .data(in_data), .arr(arr0)
  );

  stream_array_bank #(
    .BIT_WIDTH(BIT_WIDTH), .ROWS(ROWS), .COLS(COLS), .LANES(LANES), .BW(BW)
  ) u_bank1 (
    .clk(clk), .rst_n(rst_n), .we(wr & fill_sel), .beat(beat),
    .order(in_order), .data(in_data), .arr(arr1)
  );

  // Present the front bank.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        out[r][c] = front_sel ? arr1[r][c] : arr0[r][c];
      end
    end
  end

`else

  fill_state_e state, state_nxt;

  // FILL/FULL state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) begin
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  stream_array_bank #(
    .BIT_WIDTH(BIT_WIDTH), .ROWS(ROWS), .COLS(COLS), .LANES(LANES), .BW(BW)
  ) u_bank (
    .clk(clk), .rst_n(rst_n), .we(wr), .beat(beat),
    .order(in_order), .data(in_data), .arr(out)
  );

`endif

endmodule

// File: tb/tb_stream_to_3d_array.sv
// Scoreboard bench: stimulus pushes hand-computed arrays, a monitor pops on each out handshake.
// Array packing for comparison: nibble (r*3+c) holds out[r][c].
module tb_stream_to_3d_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic       in_order;
  logic [3:0] out_arr [2][3];
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [23:0] sb [$];
  bit tog_en = 1'b0;

  always #5 clk = ~clk;

  stream_to_3d_array #(
    .BIT_WIDTH(4), .ROWS(2), .COLS(3), .LANES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_order(in_order),
    .out(out_arr), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pack_out();
    logic [23:0] v;
    v = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        v[(r*3+c)*4 +: 4] = out_arr[r][c];
      end
    end
    return v;
  endfunction

  // Drive one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [7:0] d, input logic ord, input logic lst);
    int n;
    n = 0;
    in_data  = d;
    in_order = ord;
    in_last  = lst;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic ord, input logic [23:0] exp, input bit keep);
    send_beat(b0, ord, 1'b0);
    send_beat(b1, ord, 1'b0);
    send_beat(b2, ord, 1'b1);
    sb.push_back(exp);
    if (!keep) in_valid = 1'b0;
  endtask

  // Monitor: compares every presented array against the scoreboard head.
  initial begin
    logic [23:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_err) err_pulses++;
        if (!in_ready) chk("ready_low_without_valid", out_valid, 1);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_frame_sb_size", sb.size(), 1);
          end else begin
            exp = sb.pop_front();
            chk("frame_data", pack_out(), exp);
          end
        end
      end
    end
  end

  // Toggles out_ready each cycle while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) out_ready = ~out_ready;
    end
  end

  initial begin
    int n;
    time t0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_order = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_out", pack_out(), 0);
    @(posedge clk); #1;

    // Order 0: out_valid one cycle after the last beat.
    send_beat(8'h21, 1'b0, 1'b0);
    send_beat(8'h43, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_before_last", out_valid, 0);
    @(posedge clk); #1;
    send_beat(8'h65, 1'b0, 1'b1);
    sb.push_back(24'h642531);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_latency", out_valid, 1);
    @(negedge clk);
    chk("t1_valid_after_take", out_valid, 0);
    chk("t1_out_held", pack_out(), 24'h642531);
    @(posedge clk); #1;

    // Order 1, in_order toggled on later beats has no effect.
    send_beat(8'h21, 1'b1, 1'b0);
    send_beat(8'h43, 1'b0, 1'b0);
    send_beat(8'h65, 1'b1, 1'b1);
    sb.push_back(24'h654321);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_out_held", pack_out(), 24'h654321);
    chk("t2_no_frame_err", err_pulses, 0);
    @(posedge clk); #1;

`ifndef STREAM_ARRAY_DOUBLE_BUFFER_EN
    // Backpressure: next frame's first beat waits while the array is held.
    out_ready = 1'b0;
    send_frame(8'h21, 8'h43, 8'h65, 1'b1, 24'h654321, 1'b0);
    in_data = 8'h87; in_order = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_in_ready_stall", in_ready, 0);
      chk("t3_out_valid_stall", out_valid, 1);
      chk("t3_out_stable", pack_out(), 24'h654321);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_frame(8'h87, 8'hA9, 8'hCB, 1'b0, 24'hCA8B97, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
`endif

    // Framing: in_last early on beat 2 (and also on beat 3), then a frame missing in_last.
    send_beat(8'h21, 1'b0, 1'b0);
    send_beat(8'h43, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_err_pulse", frame_err, 1);
    @(negedge clk);
    chk("t4_err_single", frame_err, 0);
    @(posedge clk); #1;
    send_beat(8'h65, 1'b0, 1'b1);
    sb.push_back(24'h642531);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_err_count_a", err_pulses, 1);
    @(posedge clk); #1;
    send_beat(8'h87, 1'b0, 1'b0);
    send_beat(8'hA9, 1'b0, 1'b0);
    send_beat(8'hCB, 1'b0, 1'b0);
    sb.push_back(24'hCA8B97);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_err_count_b", err_pulses, 2);
    @(posedge clk); #1;

    // Reset mid-frame clears everything asynchronously.
    send_beat(8'h21, 1'b0, 1'b0);
    send_beat(8'h43, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_out_zero", pack_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h87, 8'hA9, 8'hCB, 1'b1, 24'hCBA987, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_out_after_reset", pack_out(), 24'hCBA987);
    @(posedge clk); #1;

`ifdef STREAM_ARRAY_DOUBLE_BUFFER_EN
    // Continuous input, out_ready toggling.
    tog_en = 1'b1;
    send_frame(8'h21, 8'h43, 8'h65, 1'b1, 24'h654321, 1'b1);
    send_frame(8'h87, 8'hA9, 8'hCB, 1'b1, 24'hCBA987, 1'b1);
    send_frame(8'hED, 8'h0F, 8'h21, 1'b1, 24'h210FED, 1'b1);
    send_frame(8'h43, 8'h65, 8'h87, 1'b1, 24'h876543, 1'b0);
    tog_en = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("db_drain", sb.size(), 0);
    @(posedge clk); #1;
    // Sustained throughput: four frames in twelve cycles.
    t0 = $time;
    send_frame(8'h21, 8'h43, 8'h65, 1'b1, 24'h654321, 1'b1);
    send_frame(8'h87, 8'hA9, 8'hCB, 1'b1, 24'hCBA987, 1'b1);
    send_frame(8'hED, 8'h0F, 8'h21, 1'b1, 24'h210FED, 1'b1);
    send_frame(8'h43, 8'h65, 8'h87, 1'b1, 24'h876543, 1'b0);
    chk("db_throughput_cycles", 32'(($time - t0) / 10), 12);
`endif

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("sb_empty_at_end", sb.size(), 0);
    chk("total_err_pulses", err_pulses, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
